// File: rtl/amm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among N_MST masters, with a
// tag FIFO that steers pipelined read data back to the master that issued it.
module amm_rr_arbiter #(
  parameter int N_MST    = 4,
  parameter int A_W      = 32,
  parameter int D_W      = 64,
  parameter int MAX_PEND = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MST-1:0]         m_write,
  input  logic [N_MST-1:0]         m_read,
  input  logic [N_MST*A_W-1:0]     m_address,
  input  logic [N_MST*D_W-1:0]     m_writedata,
  output logic [N_MST-1:0]         m_waitrequest,
  output logic [D_W-1:0]           m_readdata,
  output logic [N_MST-1:0]         m_readdatavalid,
  output logic                     s_write,
  output logic                     s_read,
  output logic [A_W-1:0]           s_address,
  output logic [D_W-1:0]           s_writedata,
  input  logic                     s_waitrequest,
  input  logic [D_W-1:0]           s_readdata,
  input  logic                     s_readdatavalid,
  output logic [$clog2(N_MST)-1:0] grant_id,
  output logic                     err_orphan
);
  localparam int GW = $clog2(N_MST);
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] tag_mem_q [MAX_PEND];
  logic [GW-1:0] tag_mem_d [MAX_PEND];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic             fifo_full, fifo_empty, push, pop, busy;
  logic             is_wr, is_rd, rd_block, done, found;
  logic [N_MST-1:0] eligible;
  logic [GW-1:0]    pick, cand;
  logic [GW:0]      sum;

  assign fifo_full  = (cnt_q == CW'(MAX_PEND));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = s_readdatavalid & ~fifo_empty & ~rst;
  assign busy       = (state_q == BUSY) & ~rst;
  assign m_readdata = s_readdata;
  assign grant_id   = (state_q == BUSY) ? gnt_q : last_q;
  assign err_orphan = err_q;

  // A read may only be issued when its tag has somewhere to go this cycle.
  always_comb begin
    s_write         = 1'b0;
    s_read          = 1'b0;
    s_address       = '0;
    s_writedata     = '0;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    is_wr           = 1'b0;
    is_rd           = 1'b0;
    rd_block        = 1'b0;
    done            = 1'b0;
    if (busy) begin
      is_wr                = m_write[gnt_q];
      is_rd                = m_read[gnt_q] & ~m_write[gnt_q];
      rd_block             = is_rd & fifo_full & ~pop;
      s_write              = is_wr;
      s_read               = is_rd & ~rd_block;
      s_address            = m_address[int'(gnt_q)*A_W +: A_W];
      s_writedata          = m_writedata[int'(gnt_q)*D_W +: D_W];
      m_waitrequest[gnt_q] = s_waitrequest | rd_block;
      done                 = (is_wr | is_rd) & ~s_waitrequest & ~rd_block;
    end
    if (pop) m_readdatavalid[tag_mem_q[rd_ptr_q]] = 1'b1;
  end

  always_comb begin
    eligible = m_write | (m_read & {N_MST{~fifo_full}});
    found    = 1'b0;
    pick     = last_q;
    sum      = '0;
    cand     = '0;
    for (int k = 1; k <= N_MST; k++) begin
      sum = {1'b0, last_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_MST)) sum = sum - (GW+1)'(N_MST);
      cand = sum[GW-1:0];
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    push      = 1'b0;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q | (s_readdatavalid & fifo_empty);
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A master dropping its request mid-command is abandoned silently.
        if (!(is_wr || is_rd) || done) state_d = IDLE;
        if (done) begin
          last_d = gnt_q;
          push   = is_rd;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      tag_mem_d[wr_ptr_q] = gnt_q;
      wr_ptr_d = (wr_ptr_q == PW'(MAX_PEND-1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_PEND-1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      last_q   <= GW'(N_MST-1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end
endmodule
